// File: rtl/ifetch_pkg.sv
// Shared widths, FSM state type and response record for the instruction-fetch responder.
package ifetch_pkg;

    localparam int unsigned ADDR_W = 25;
    localparam int unsigned INSN_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        WT0,
        RD1,
        WT1,
        ERR
    } ifr_state_e;

    typedef struct packed {
        logic [INSN_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              err;
    } ifr_rsp_t;

    function automatic logic [ADDR_W-3:0] word_addr(input logic [ADDR_W-1:0] byte_addr);
        return byte_addr[ADDR_W-1:2];
    endfunction

endpackage

// File: rtl/ifr_rsp_fifo.sv
// In-order response FIFO for ifetch_responder; head entry is shown directly from storage.
module ifr_rsp_fifo
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  ifr_rsp_t               i_data,
    input  logic                   i_pop,
    output ifr_rsp_t               o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    ifr_rsp_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Empty FIFO presents an all-zero head so rsp_* read 0 when nothing is valid.
    assign o_head  = o_empty ? '0 : r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_mem   <= '{default: '0};
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_responder.sv
// Instruction-memory responder: halfword-granular fetches, split/reassembly of misaligned
// windows, in-order response FIFO. Optional counters: define IFETCH_RESPONDER_STATS_EN.
module ifetch_responder
    import ifetch_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned RSP_DEPTH   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [INSN_W-1:0] rsp_data_o,
    output logic [ADDR_W-1:0] rsp_addr_o,
    output logic              rsp_err_o,
    output logic              mem_en_o,
    output logic [ADDR_W-3:0] mem_addr_o,
    input  logic [INSN_W-1:0] mem_rdata_i
`ifdef IFETCH_RESPONDER_STATS_EN
    ,
    output logic [15:0]       stat_fetch_o,
    output logic [15:0]       stat_split_o
`endif
);

    localparam int unsigned WA_W  = ADDR_W - 2;
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH) + 1;

    ifr_state_e        r_state;
    ifr_state_e        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_wait;
    logic [15:0]       r_lo;
    logic              w_accept;
    logic              w_wait_done;
    logic              w_push;
    ifr_rsp_t          w_push_data;
    ifr_rsp_t          w_head;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;
    logic [WA_W-1:0]   w_word;

    assign w_word      = word_addr(r_addr);
    assign w_wait_done = (r_wait == 3'(WAIT_STATES));
    assign req_ready_o = (r_state == IDLE) && (w_count < CNT_W'(RSP_DEPTH)) && !rst;
    assign w_accept    = req_valid_i && req_ready_o;

    always_comb begin
        w_next      = r_state;
        w_push      = 1'b0;
        w_push_data = '0;
        mem_en_o    = 1'b0;
        mem_addr_o  = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = req_addr_i[0] ? ERR : RD0;
                end
            end
            ERR: begin
                w_push           = 1'b1;
                w_push_data.addr = r_addr;
                w_push_data.err  = 1'b1;
                w_next           = IDLE;
            end
            RD0: begin
                mem_en_o   = 1'b1;
                mem_addr_o = w_word;
                w_next     = WT0;
            end
            WT0: begin
                if (w_wait_done) begin
                    if (r_addr[1]) begin
                        w_next = RD1;
                    end else begin
                        w_push           = 1'b1;
                        w_push_data.data = mem_rdata_i;
                        w_push_data.addr = r_addr;
                        w_next           = IDLE;
                    end
                end
            end
            RD1: begin
                mem_en_o   = 1'b1;
                mem_addr_o = w_word + 1'b1;
                w_next     = WT1;
            end
            WT1: begin
                if (w_wait_done) begin
                    w_push           = 1'b1;
                    w_push_data.data = {mem_rdata_i[15:0], r_lo};
                    w_push_data.addr = r_addr;
                    w_next           = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wait  <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr <= req_addr_i;
            end
            if ((r_state == WT0 || r_state == WT1) && !w_wait_done) begin
                r_wait <= r_wait + 1'b1;
            end else begin
                r_wait <= '0;
            end
            if (r_state == WT0 && w_wait_done) begin
                r_lo <= mem_rdata_i[31:16];
            end
        end
    end

    ifr_rsp_fifo #(
        .DEPTH(RSP_DEPTH)
    ) u_rsp_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_push),
        .i_data (w_push_data),
        .i_pop  (rsp_ready_i),
        .o_head (w_head),
        .o_count(w_count),
        .o_full (w_full),
        .o_empty(w_empty)
    );

    // The slot is reserved when the request is accepted, so a push can never meet a full FIFO.
    a_push_has_room: assert property (@(posedge clk) disable iff (rst) (w_push |-> !w_full));

    assign rsp_valid_o = !w_empty;
    assign rsp_data_o  = w_head.data;
    assign rsp_addr_o  = w_head.addr;
    assign rsp_err_o   = w_head.err;

`ifdef IFETCH_RESPONDER_STATS_EN
    logic [15:0] r_stat_fetch;
    logic [15:0] r_stat_split;
    logic        w_split;

    assign w_split = (r_state == WT1) && w_wait_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_fetch <= '0;
            r_stat_split <= '0;
        end else begin
            if (w_push && r_stat_fetch != '1) begin
                r_stat_fetch <= r_stat_fetch + 1'b1;
            end
            if (w_split && r_stat_split != '1) begin
                r_stat_split <= r_stat_split + 1'b1;
            end
        end
    end

    assign stat_fetch_o = r_stat_fetch;
    assign stat_split_o = r_stat_split;
`endif

endmodule
